// File: rtl/saturn_alu_sequencer.sv
// Nibble-serial sequencer that walks a pointer window over two latched 64-bit sources for the ALU.
// Optional build macro SATURN_ALU_SEQ_BUSY_ERR_EN adds o_start_err, flagging starts requested while busy.
module saturn_alu_sequencer #(
  parameter int NIBBLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_start,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_ptr_begin,
  input  logic [3:0]  i_ptr_end,
  input  logic [63:0] i_src_1,
  input  logic [63:0] i_src_2,
  input  logic        i_carry,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_ptr_begin,
  output logic [3:0]  o_ptr_end,
  output logic        o_run,
  output logic        o_done,
  output logic [3:0]  o_prep_src_1_val,
  output logic [3:0]  o_prep_src_2_val,
  output logic        o_prep_carry,
  output logic [3:0]  o_calc_pos,
  input  logic [3:0]  i_calc_res_1_val,
  input  logic [3:0]  i_calc_res_2_val,
  input  logic        i_calc_carry,
  output logic [63:0] o_res_1,
  output logic [63:0] o_res_2,
  output logic        o_carry,
  output logic        o_busy
`ifdef SATURN_ALU_SEQ_BUSY_ERR_EN
  ,
  output logic        o_start_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_opcode;
  logic [3:0]  r_ptr_begin;
  logic [3:0]  r_ptr_end;
  logic [63:0] r_src_1;
  logic [63:0] r_src_2;
  logic [3:0]  r_pos;
  logic        r_carry;
  logic [63:0] r_res_1;
  logic [63:0] r_res_2;
  logic        r_run;
  logic        r_done;
  logic        r_busy;

  logic        w_in_run;
  logic [3:0]  w_src_1_nib [NIBBLES];
  logic [3:0]  w_src_2_nib [NIBBLES];
  logic [NIBBLES-1:0] w_wr_en;
  logic [63:0] w_res_1_next;
  logic [63:0] w_res_2_next;

  assign w_in_run = (r_state == ST_RUN);

  // Per-nibble views of the sources and the write-back merge of the ALU results.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign w_src_1_nib[gi] = r_src_1[4*gi +: 4];
    assign w_src_2_nib[gi] = r_src_2[4*gi +: 4];
    assign w_wr_en[gi]     = (r_pos == 4'(gi));
    assign w_res_1_next[4*gi +: 4] = w_wr_en[gi] ? i_calc_res_1_val : r_res_1[4*gi +: 4];
    assign w_res_2_next[4*gi +: 4] = w_wr_en[gi] ? i_calc_res_2_val : r_res_2[4*gi +: 4];
  end

  // ALU-facing signals are only meaningful while walking; keep them quiet otherwise.
  assign o_prep_src_1_val = w_in_run ? w_src_1_nib[r_pos] : 4'd0;
  assign o_prep_src_2_val = w_in_run ? w_src_2_nib[r_pos] : 4'd0;
  assign o_prep_carry     = w_in_run ? r_carry : 1'b0;
  assign o_calc_pos       = w_in_run ? r_pos : 4'd0;

  assign o_opcode    = r_opcode;
  assign o_ptr_begin = r_ptr_begin;
  assign o_ptr_end   = r_ptr_end;
  assign o_res_1     = r_res_1;
  assign o_res_2     = r_res_2;
  assign o_carry     = r_carry;
  assign o_run       = r_run;
  assign o_done      = r_done;
  assign o_busy      = r_busy;

`ifdef SATURN_ALU_SEQ_BUSY_ERR_EN
  logic r_start_err;
  assign o_start_err = r_start_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_start_err <= 1'b0;
    end else if (i_clk_en) begin
      r_start_err <= i_start && r_busy;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_opcode    <= 5'd0;
      r_ptr_begin <= 4'd0;
      r_ptr_end   <= 4'd0;
      r_src_1     <= 64'd0;
      r_src_2     <= 64'd0;
      r_pos       <= 4'd0;
      r_carry     <= 1'b0;
      r_res_1     <= 64'd0;
      r_res_2     <= 64'd0;
      r_run       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_opcode    <= i_opcode;
            r_ptr_begin <= i_ptr_begin;
            r_ptr_end   <= i_ptr_end;
            r_src_1     <= i_src_1;
            r_src_2     <= i_src_2;
            r_res_1     <= i_src_1;
            r_res_2     <= i_src_2;
            r_carry     <= i_carry;
            r_pos       <= i_ptr_begin;
            r_state     <= ST_RUN;
            r_run       <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          r_res_1 <= w_res_1_next;
          r_res_2 <= w_res_2_next;
          r_carry <= i_calc_carry;
          if (r_pos == r_ptr_end) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            // 4-bit increment wraps F->0 naturally.
            r_pos <= r_pos + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_run   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_run   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_alu_sequencer.sv
// Randomized bench for saturn_alu_sequencer with an add-carry ALU and a nibble-walk reference model.
module tb_saturn_alu_sequencer;

  logic        clk;
  logic        i_reset;
  logic        i_clk_en;
  logic        i_start;
  logic [4:0]  i_opcode;
  logic [3:0]  i_ptr_begin;
  logic [3:0]  i_ptr_end;
  logic [63:0] i_src_1;
  logic [63:0] i_src_2;
  logic        i_carry;
  logic [4:0]  o_opcode;
  logic [3:0]  o_ptr_begin;
  logic [3:0]  o_ptr_end;
  logic        o_run;
  logic        o_done;
  logic [3:0]  o_prep_src_1_val;
  logic [3:0]  o_prep_src_2_val;
  logic        o_prep_carry;
  logic [3:0]  o_calc_pos;
  logic [3:0]  i_calc_res_1_val;
  logic [3:0]  i_calc_res_2_val;
  logic        i_calc_carry;
  logic [63:0] o_res_1;
  logic [63:0] o_res_2;
  logic        o_carry;
  logic        o_busy;
`ifdef SATURN_ALU_SEQ_BUSY_ERR_EN
  logic        o_start_err;
`endif

  int total = 0;
  int bad   = 0;

  saturn_alu_sequencer dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_clk_en(i_clk_en),
    .i_start(i_start),
    .i_opcode(i_opcode),
    .i_ptr_begin(i_ptr_begin),
    .i_ptr_end(i_ptr_end),
    .i_src_1(i_src_1),
    .i_src_2(i_src_2),
    .i_carry(i_carry),
    .o_opcode(o_opcode),
    .o_ptr_begin(o_ptr_begin),
    .o_ptr_end(o_ptr_end),
    .o_run(o_run),
    .o_done(o_done),
    .o_prep_src_1_val(o_prep_src_1_val),
    .o_prep_src_2_val(o_prep_src_2_val),
    .o_prep_carry(o_prep_carry),
    .o_calc_pos(o_calc_pos),
    .i_calc_res_1_val(i_calc_res_1_val),
    .i_calc_res_2_val(i_calc_res_2_val),
    .i_calc_carry(i_calc_carry),
    .o_res_1(o_res_1),
    .o_res_2(o_res_2),
    .o_carry(o_carry),
    .o_busy(o_busy)
`ifdef SATURN_ALU_SEQ_BUSY_ERR_EN
    ,
    .o_start_err(o_start_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: res_1 = src_1 + carry, res_2 = src_2 xor opcode[3:0].
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, o_prep_src_1_val} + {4'd0, o_prep_carry};
  end
  assign i_calc_res_1_val = alu_sum[3:0];
  assign i_calc_carry     = alu_sum[4];
  assign i_calc_res_2_val = o_prep_src_2_val ^ o_opcode[3:0];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    i_opcode    = 5'($urandom);
    i_ptr_begin = 4'($urandom);
    i_ptr_end   = 4'($urandom);
    i_src_1     = {$urandom, $urandom};
    i_src_2     = {$urandom, $urandom};
    i_carry     = 1'($urandom);
  endtask

  task automatic run_op(input logic [3:0] b, input logic [3:0] e,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input logic c, input logic [4:0] op,
                        input int stall_k, input int busy_k,
                        input bit done_stall, input bit done_start);
    int n;
    logic [63:0] m1, m2;
    logic mc;
    logic [3:0] p;
    logic [4:0] s;
    logic [3:0] a1, a2;
    logic [3:0] diff;
    diff = e - b;
    n = int'(diff) + 1;
    @(negedge clk);
    i_opcode = op; i_ptr_begin = b; i_ptr_end = e;
    i_src_1 = s1; i_src_2 = s2; i_carry = c; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    scramble_inputs();
    m1 = s1; m2 = s2; mc = c; p = b;
    check_val("latch_opcode", 64'(o_opcode), 64'(op));
    check_val("latch_begin", 64'(o_ptr_begin), 64'(b));
    check_val("latch_end", 64'(o_ptr_end), 64'(e));
    for (int k = 0; k < n; k++) begin
      if (k == stall_k) begin
        i_clk_en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("stall_pos", 64'(o_calc_pos), 64'(p));
          check_val("stall_res1", o_res_1, m1);
          check_val("stall_run", 64'(o_run), 64'd1);
        end
        i_clk_en = 1'b1;
      end
      a1 = s1[4*p +: 4];
      a2 = s2[4*p +: 4];
      check_val("calc_pos", 64'(o_calc_pos), 64'(p));
      check_val("prep_src1", 64'(o_prep_src_1_val), 64'(a1));
      check_val("prep_src2", 64'(o_prep_src_2_val), 64'(a2));
      check_val("prep_carry", 64'(o_prep_carry), 64'(mc));
      check_val("run_res1", o_res_1, m1);
      check_val("run_done", 64'(o_done), 64'd0);
      if (k == busy_k) i_start = 1'b1;
      s = {1'b0, a1} + {4'd0, mc};
      m1[4*p +: 4] = s[3:0];
      m2[4*p +: 4] = a2 ^ op[3:0];
      mc = s[4];
      p = p + 4'd1;
      @(negedge clk);
      i_start = 1'b0;
      check_val("no_relatch", 64'(o_opcode), 64'(op));
`ifdef SATURN_ALU_SEQ_BUSY_ERR_EN
      check_val("start_err", 64'(o_start_err), (k == busy_k) ? 64'd1 : 64'd0);
`endif
    end
    check_val("done_pulse", 64'(o_done), 64'd1);
    if (done_stall) begin
      i_clk_en = 1'b0;
      @(negedge clk);
      check_val("done_stretch", 64'(o_done), 64'd1);
      i_clk_en = 1'b1;
    end
    check_val("done_run", 64'(o_run), 64'd1);
    check_val("done_busy", 64'(o_busy), 64'd1);
    check_val("done_pos_quiet", 64'(o_calc_pos), 64'd0);
    check_val("res1", o_res_1, m1);
    check_val("res2", o_res_2, m2);
    check_val("carry", 64'(o_carry), 64'(mc));
    if (done_start) i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_val("idle_done", 64'(o_done), 64'd0);
    check_val("idle_busy", 64'(o_busy), 64'd0);
    check_val("idle_run", 64'(o_run), 64'd0);
    check_val("hold_res1", o_res_1, m1);
    check_val("hold_carry", 64'(o_carry), 64'(mc));
    $display("op b=%h e=%h n=%0d src1=%h res1=%h carry=%0d stall=%0d busy=%0d", b, e, n, s1, m1, mc, stall_k, busy_k);
  endtask

  initial begin
    i_reset = 1'b1; i_clk_en = 1'b1; i_start = 1'b0;
    i_opcode = '0; i_ptr_begin = '0; i_ptr_end = '0;
    i_src_1 = '0; i_src_2 = '0; i_carry = 1'b0;
    repeat (3) @(negedge clk);
    i_start = 1'b1;
    scramble_inputs();
    @(negedge clk);
    check_val("rst_busy", 64'(o_busy), 64'd0);
    check_val("rst_res1", o_res_1, 64'd0);
    check_val("rst_res2", o_res_2, 64'd0);
    check_val("rst_opcode", 64'(o_opcode), 64'd0);
    check_val("rst_flags", {o_run, o_done, o_carry, o_prep_carry}, 64'd0);
    check_val("rst_pos", 64'(o_calc_pos), 64'd0);
    i_start = 1'b0;
    i_reset = 1'b0;
    @(negedge clk);
    check_val("idle_after_rst", 64'(o_busy), 64'd0);

    run_op(4'h3, 4'h3, 64'd0, 64'd0, 1'b1, 5'd0, -1, -1, 1'b0, 1'b0);
    check_val("single_res1", o_res_1, 64'h0000_0000_0000_1000);

    run_op(4'h0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd5, -1, -1, 1'b0, 1'b0);
    check_val("full_res1", o_res_1, 64'd0);
    check_val("full_carry", 64'(o_carry), 64'd1);

    run_op(4'hE, 4'h1, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444, 1'b0, 5'd9, -1, -1, 1'b0, 1'b0);
    run_op(4'h2, 4'h9, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 5'd3, 3, 5, 1'b1, 1'b1);
    run_op(4'h5, 4'h4, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 5'd7, 15, 15, 1'b0, 1'b1);

    // Abort a 0..F walk once position 5 is presented.
    @(negedge clk);
    i_opcode = 5'd1; i_ptr_begin = 4'h0; i_ptr_end = 4'hF;
    i_src_1 = 64'hFFFF_FFFF_FFFF_FFFF; i_src_2 = 64'h5555; i_carry = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_abort_pos", 64'(o_calc_pos), 64'd5);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_val("abort_busy", 64'(o_busy), 64'd0);
    check_val("abort_res1", o_res_1, 64'd0);
    check_val("abort_res2", o_res_2, 64'd0);
    check_val("abort_opcode", 64'(o_opcode), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_no_done", 64'(o_done), 64'd0);
    end

    for (int t = 0; t < 30; t++) begin
      logic [3:0] rb, re;
      int sk, bk;
      rb = 4'($urandom);
      re = 4'($urandom);
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      bk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_op(rb, re, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
             sk, bk, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saturn_alu_sequencer.md
Name: saturn_alu_sequencer

Overview:
- Upstream driver of the nibble-serial ALU datapath.
- Latches two 64-bit source registers, an opcode, a field pointer window and a carry-in.
- Walks the nibble positions from ptr_begin to ptr_end, one position per enabled clock, presenting source nibbles, position and running carry to the ALU.
- Captures the ALU's per-nibble results and carry into 64-bit result registers and reports completion with a one-cycle done pulse.

Parameters:
- NIBBLES, 16, nibbles per register. Fixed at 16; 64-bit words, 4-bit positions.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  advance enable; when low, all state and outputs hold.
- i_start  in  1  request; sampled only in IDLE with i_clk_en high.
- i_opcode  in  5  ALU opcode; latched at start.
- i_ptr_begin  in  4  first nibble position; latched at start.
- i_ptr_end  in  4  last nibble position; latched at start.
- i_src_1  in  64  source register 1; latched at start.
- i_src_2  in  64  source register 2; latched at start.
- i_carry  in  1  carry-in; latched at start.
- o_opcode  out  5  latched opcode to the ALU.
- o_ptr_begin  out  4  latched begin pointer.
- o_ptr_end  out  4  latched end pointer.
- o_run  out  1  high in RUN and DONE.
- o_done  out  1  high in DONE only.
- o_prep_src_1_val  out  4  nibble of latched src_1 at the current position.
- o_prep_src_2_val  out  4  nibble of latched src_2 at the current position.
- o_prep_carry  out  1  running carry register.
- o_calc_pos  out  4  current nibble position.
- i_calc_res_1_val  in  4  ALU result 1 for o_calc_pos.
- i_calc_res_2_val  in  4  ALU result 2 for o_calc_pos.
- i_calc_carry  in  1  ALU carry-out for o_calc_pos.
- o_res_1  out  64  result register 1.
- o_res_2  out  64  result register 2.
- o_carry  out  1  final carry.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, RUN, DONE. Every transition requires i_clk_en=1.
- Reset: state=IDLE, pos=0, carry=0; all outputs 0, including o_res_1, o_res_2 and latched fields.
- Reset mid-operation: abort to IDLE; no done pulse; results cleared.
- IDLE with i_start:
  - Latch all inputs.
  - o_res_1 <= i_src_1, o_res_2 <= i_src_2, carry <= i_carry, pos <= i_ptr_begin.
  - Go to RUN.
- RUN, each enabled edge:
  - Write res_1[4*pos+:4] <= i_calc_res_1_val and res_2[4*pos+:4] <= i_calc_res_2_val.
  - carry <= i_calc_carry.
  - If pos==ptr_end, go to DONE; else pos <= pos+1, wrapping F->0.
- Nibble count N = ((ptr_end - ptr_begin) mod 16) + 1, range 1..16.
  - begin==end gives 1 nibble.
  - end<begin wraps through F to 0.
  - begin=end+1 gives 16 nibbles.
- Nibbles outside the window keep their source values.
- DONE: o_done=1 for exactly one enabled cycle, then IDLE. o_res_1, o_res_2 and o_carry hold until the next start or reset.
- Latency: start accepted at enabled edge k; RUN occupies enabled cycles k+1..k+N; DONE at k+N+1; IDLE at k+N+2.
- i_start while busy: ignored; no relatch.
- i_start in the same cycle as DONE: ignored. A new start is accepted no earlier than the first IDLE cycle.
- i_clk_en low: pos, state, carry, results and o_done all frozen. The done pulse stretches across disabled cycles.
- o_prep_* and o_calc_pos are combinational from latched sources and pos. They are valid only in RUN and forced to 0 otherwise.

Optional Feature:
- Macro: SATURN_ALU_SEQ_BUSY_ERR_EN.
- Defined:
  - Adds output o_start_err (1 bit, reset 0).
  - o_start_err pulses high for one enabled cycle when i_start=1 while o_busy=1.
  - The rejected request still has no other effect.
- Undefined: port absent; start-while-busy silently ignored.

Test Plan:
- Reset then idle:
  - Expected: all outputs 0, o_busy=0.
  - i_start while i_reset=1: remains IDLE.
- Single nibble:
  - Stimulus: begin=end=3, src_1=0x...0000_0000, src_2=0, i_carry=1; ALU model returns res_1 = src_1+1 per nibble.
  - Expected: one RUN cycle with o_calc_pos=3; DONE on the next cycle; o_res_1=0x0000_0000_0000_1000; other nibbles unchanged.
- Full word with carry chain:
  - Stimulus: begin=0, end=F, src_1=0xFFFF_FFFF_FFFF_FFFF, ALU adds carry.
  - Expected: 16 RUN cycles, o_res_1=0, o_carry=1, o_done after cycle 17.
- Wrap-around:
  - Stimulus: begin=E, end=1.
  - Expected: o_calc_pos sequence E,F,0,1; only nibbles E,F,0,1 modified.
- Clock-enable stall and busy start:
  - Stimulus: drop i_clk_en for 3 cycles mid-RUN; pulse i_start during RUN.
  - Expected: pos and results frozen during the stall; total enabled RUN cycles still N; second start ignored. With the macro defined, o_start_err=1 for one cycle.
- Reset mid-run:
  - Stimulus: assert i_reset at pos=5 of a 0..F run.
  - Expected: next cycle IDLE, o_done never pulses, o_res_1=0.
